// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: EX operand select codes, IF/ID stall, load-use bubbles.
// Define HAZARD_FWD_EN to enable forwarding; otherwise RAW hazards stall until the producer reaches WB.
module hazard_forward_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic [4:0]  id_dst,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        flush,
   output logic        stall,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        ex_bubble,
   output logic [15:0] stall_cnt
);

   // WB is not tracked: the register file is write-through, so a WB producer never needs handling.
   logic       ex_valid;
   logic       ex_wr;
   logic       ex_load;
   logic [4:0] ex_dst;
   logic       mem_valid;
   logic       mem_wr;
   logic [4:0] mem_dst;

   logic       id_live;
   logic       advance;
   logic       a_ex;
   logic       b_ex;
   logic       a_mem;
   logic       b_mem;
   logic [1:0] fwd_a_nxt;
   logic [1:0] fwd_b_nxt;

   function automatic logic hit(input logic use_src, input logic [4:0] src,
                                input logic v, input logic w, input logic [4:0] dst);
      return use_src & v & w & (dst == src) & (src != 5'd0);
   endfunction

   always_comb begin
      a_ex    = hit(id_use_rs, id_rs, ex_valid, ex_wr, ex_dst);
      b_ex    = hit(id_use_rt, id_rt, ex_valid, ex_wr, ex_dst);
      a_mem   = hit(id_use_rs, id_rs, mem_valid, mem_wr, mem_dst);
      b_mem   = hit(id_use_rt, id_rt, mem_valid, mem_wr, mem_dst);
      id_live = id_valid & ~flush;
`ifdef HAZARD_FWD_EN
      stall     = id_live & ex_load & (a_ex | b_ex);
      fwd_a_nxt = a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
      fwd_b_nxt = b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
`else
      stall     = id_live & (a_ex | b_ex | a_mem | b_mem);
      fwd_a_nxt = 2'b00;
      fwd_b_nxt = 2'b00;
`endif
      advance = id_live & ~stall;
   end

`ifndef HAZARD_FWD_EN
   // Load tracking only matters for forwarding; without it every producer is handled alike.
   logic unused_ex_load;
   assign unused_ex_load = ex_load;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_wr     <= 1'b0;
         ex_load   <= 1'b0;
         ex_dst    <= 5'd0;
         mem_valid <= 1'b0;
         mem_wr    <= 1'b0;
         mem_dst   <= 5'd0;
         fwd_a_sel <= 2'b00;
         fwd_b_sel <= 2'b00;
         stall_cnt <= 16'd0;
      end else begin
         mem_valid <= ex_valid;
         mem_wr    <= ex_wr;
         mem_dst   <= ex_dst;
         ex_valid  <= advance;
         ex_wr     <= advance & id_reg_write;
         ex_load   <= advance & id_mem_read;
         ex_dst    <= advance ? id_dst : 5'd0;
         fwd_a_sel <= advance ? fwd_a_nxt : 2'b00;
         fwd_b_sel <= advance ? fwd_b_nxt : 2'b00;
         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign ex_bubble = ~ex_valid;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl; expectations follow whichever build HAZARD_FWD_EN selects.
module tb_hazard_forward_ctrl;

`ifdef HAZARD_FWD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif
   localparam int D1      = FWD ? 0 : 2;
   localparam int D2      = FWD ? 0 : 1;
   localparam int LD      = FWD ? 1 : 2;
   localparam int SEL_EX  = FWD ? 1 : 0;
   localparam int SEL_MEM = FWD ? 2 : 0;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic [4:0]  id_dst;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        flush;
   logic        stall;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic        ex_bubble;
   logic [15:0] stall_cnt;

   int vectors;
   int miscompares;
   int seen;

   hazard_forward_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ins(input int dst, input int wr, input int ld,
                          input int rs, input int urs, input int rt, input int urt);
      id_valid     = 1'b1;
      flush        = 1'b0;
      id_dst       = 5'(dst);
      id_reg_write = 1'(wr);
      id_mem_read  = 1'(ld);
      id_rs        = 5'(rs);
      id_use_rs    = 1'(urs);
      id_rt        = 5'(rt);
      id_use_rt    = 1'(urt);
      #1;
   endtask

   task automatic set_nop;
      id_valid = 1'b0;
      flush    = 1'b0;
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      set_nop();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Consumer already in ID: expect n stall cycles with bubbles, then release into EX.
   task automatic hold_stall(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_stall"}, 32'(stall), 1);
         tick();
         chk({tag, "_bubble"}, 32'(ex_bubble), 1);
      end
      chk({tag, "_release"}, 32'(stall), 0);
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      seen        = 0;
      rst_n       = 1'b0;
      set_nop();
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_dst = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;

      // Reset held for two cycles, with a would-be load-use pattern at ID
      tick();
      tick();
      set_ins(6, 1, 1, 5, 1, 5, 1);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_fwd_a", 32'(fwd_a_sel), 0);
      chk("rst_fwd_b", 32'(fwd_b_sel), 0);
      chk("rst_bubble", 32'(ex_bubble), 1);
      chk("rst_cnt", 32'(stall_cnt), 0);
      rst_n = 1'b1;

      // ALU chain at distance 1
      do_reset();
      set_ins(3, 1, 0, 1, 1, 2, 1);
      chk("d1_prod_stall", 32'(stall), 0);
      tick();
      set_ins(4, 1, 0, 3, 1, 6, 1);
      hold_stall("d1", D1);
      chk("d1_fwd_a", 32'(fwd_a_sel), SEL_EX);
      chk("d1_fwd_b", 32'(fwd_b_sel), 0);
      chk("d1_ex_bubble", 32'(ex_bubble), 0);
      chk("d1_cnt", 32'(stall_cnt), D1);

      // ALU chain at distance 2
      do_reset();
      set_ins(3, 1, 0, 1, 1, 2, 1);
      tick();
      set_ins(8, 1, 0, 9, 1, 10, 1);
      chk("d2_indep_stall", 32'(stall), 0);
      tick();
      set_ins(4, 1, 0, 3, 1, 6, 1);
      hold_stall("d2", D2);
      chk("d2_fwd_a", 32'(fwd_a_sel), SEL_MEM);
      chk("d2_fwd_b", 32'(fwd_b_sel), 0);
      chk("d2_cnt", 32'(stall_cnt), D2);

      // Load-use on rt, followed by a flushed load-use that must not count
      do_reset();
      set_ins(5, 1, 1, 1, 1, 0, 0);
      tick();
      set_ins(6, 1, 0, 2, 1, 5, 1);
      hold_stall("lu", LD);
      chk("lu_fwd_b", 32'(fwd_b_sel), SEL_MEM);
      chk("lu_fwd_a", 32'(fwd_a_sel), 0);
      chk("lu_ex_bubble", 32'(ex_bubble), 0);
      chk("lu_cnt", 32'(stall_cnt), LD);
      set_ins(9, 1, 1, 1, 1, 0, 0);
      chk("fl_load_stall", 32'(stall), 0);
      tick();
      set_ins(10, 1, 0, 9, 1, 0, 0);
      flush = 1'b1;
      #1;
      chk("fl_stall", 32'(stall), 0);
      tick();
      chk("fl_bubble", 32'(ex_bubble), 1);
      chk("fl_fwd_a", 32'(fwd_a_sel), 0);
      chk("fl_cnt", 32'(stall_cnt), LD);
      set_nop();

      // Register 0 never matches
      do_reset();
      set_ins(0, 1, 0, 1, 1, 2, 1);
      tick();
      set_ins(11, 1, 0, 0, 1, 0, 1);
      chk("r0_stall", 32'(stall), 0);
      tick();
      chk("r0_fwd_a", 32'(fwd_a_sel), 0);
      chk("r0_fwd_b", 32'(fwd_b_sel), 0);
      chk("r0_ex_bubble", 32'(ex_bubble), 0);

      // $7 written at distance 2 and 1, read on both sources: EX wins
      do_reset();
      set_ins(7, 1, 0, 1, 1, 0, 0);
      tick();
      set_ins(7, 1, 0, 2, 1, 0, 0);
      chk("pri_mid_stall", 32'(stall), 0);
      tick();
      set_ins(12, 1, 0, 7, 1, 7, 1);
      hold_stall("pri", D1);
      chk("pri_fwd_a", 32'(fwd_a_sel), SEL_EX);
      chk("pri_fwd_b", 32'(fwd_b_sel), SEL_EX);

      // Reset asserted while a stall is active
      do_reset();
      set_ins(5, 1, 1, 1, 1, 0, 0);
      tick();
      set_ins(6, 1, 0, 5, 1, 0, 0);
      chk("rms_stall", 32'(stall), 1);
      rst_n = 1'b0;
      tick();
      chk("rms_stall_after", 32'(stall), 0);
      chk("rms_cnt", 32'(stall_cnt), 0);
      chk("rms_bubble", 32'(ex_bubble), 1);
      rst_n = 1'b1;

      // Saturation: a self-dependent load held at ID stalls repeatedly
      do_reset();
      set_ins(5, 1, 1, 5, 1, 0, 0);
      for (int c = 0; c < 140000 && seen < 65540; c++) begin
         if (stall) seen++;
         tick();
      end
      chk("sat_stalls_seen", 32'(seen >= 65540), 1);
      chk("sat_cnt", 32'(stall_cnt), 65535);
      set_nop();
      tick();
      chk("sat_hold", 32'(stall_cnt), 65535);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
